// File: rtl/serial_sub.sv
// serial_sub: bit-serial unsigned subtractor, a - b, LSB first.
// One full-subtractor cell is reused over WIDTH clocks, with the borrow
// carried between clocks in a register. diff/borr load only on completion
// and then hold until the next completion or reset.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             bin;
  logic [CW-1:0]    cnt;
  logic             armed;
  logic             d_bit;
  logic             b_bit;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs and the registered borrow.
  always_comb begin
    d_bit = sa[0] ^ sb[0] ^ bin;
    b_bit = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bin);
  end

  // The counter runs 0..WIDTH-1, so it never wraps before the last bit.
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Goes high at the first edge after reset release; a start arriving on
  // that same edge is therefore ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // Control FSM plus operand, result and borrow datapath.
  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values of the others, exactly like real flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      bin   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      borr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && armed) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            bin   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {d_bit, res[WIDTH-1:1]};
          bin <= b_bit;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            diff  <= {d_bit, res[WIDTH-1:1]};
            borr  <= b_bit;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: randomized scoreboard bench for serial_sub (WIDTH=8).
// The driver pushes the expected difference/borrow computed with plain
// arithmetic; a negedge monitor pops and compares on every done pulse.
module tb_serial_sub;

  localparam int WIDTH = 8;
  localparam int N_RAND = 2500;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borr;
  } result_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borr;

  int checks = 0;
  int errors = 0;

  result_t exp_q[$];
  result_t hold;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borr  (borr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned subtraction modulo 2^WIDTH; borrow iff x < y.
  function automatic result_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    result_t r;
    r.diff = x - y;
    r.borr = (x < y);
    return r;
  endfunction

  // Monitor: pop on each done pulse; while busy the outputs must hold.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("borr", 32'(borr), 32'(e.borr));
        hold = e;
      end
    end else if (rst_n && busy) begin
      check("hold_while_busy", 32'({diff, borr}), 32'({hold.diff, hold.borr}));
    end
  end

  // One complete operation with cycle-exact busy/done timing checks.
  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(model(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    for (int i = 0; i < WIDTH; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) check("busy_phase", 32'({busy, done}), 32'b10);
      @(posedge clk);
      #1;
    end
    check("done_phase", 32'({busy, done}), 32'b01);
    @(posedge clk);
    #1;
    check("idle_after_done", 32'({busy, done}), 32'b00);
  endtask

  initial begin
    logic [WIDTH-1:0] corner_a [6];
    logic [WIDTH-1:0] corner_b [6];
    corner_a = '{8'h35, 8'h12, 8'h00, 8'hA5, 8'hFF, 8'h00};
    corner_b = '{8'h12, 8'h35, 8'h01, 8'hA5, 8'h00, 8'hFF};

    hold  = '0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_outputs", 32'({busy, done, diff, borr}), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, including the full borrow ripple and equal operands.
    for (int i = 0; i < 6; i++) do_op(corner_a[i], corner_b[i]);

    // start held high with changing operands: only the captured ones count,
    // and the next operation begins at edge k+WIDTH+2.
    @(negedge clk);
    start = 1'b1;
    a = 8'h9C;
    b = 8'h3E;
    exp_q.push_back(model(8'h9C, 8'h3E));
    for (int c = 1; c <= WIDTH + 2; c++) begin
      @(negedge clk);
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if (c == WIDTH + 2) exp_q.push_back(model(a, b));
    end
    @(posedge clk);
    #1;
    check("restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (WIDTH + 2) @(posedge clk);
    #1;
    check("held_start_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset 3 cycles into a run: immediate clear, no done pulse.
    @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", 32'({busy, done, diff, borr}), 32'd0);
    hold = '0;
    repeat (2) @(posedge clk);
    // start presented on the very edge that first sees reset released.
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_at_release_ignored", 32'(busy), 32'd0);
    do_op(8'h80, 8'h01);
    check("post_reset_diff", 32'(diff), 32'h7F);

    // Randomized operands.
    for (int i = 0; i < N_RAND; i++) do_op(WIDTH'($urandom), WIDTH'($urandom));

    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
